temp_sample_controller: RTL
===========================

Name: temp_sample_controller

Overview:
- Sequences one measurement cycle of the temperature datapath: periodic ADC conversion requests, averaging of 2^AVG_LOG2 samples, presentation of the averaged sample plus base/reference configuration to the TemperatureCalculator, and capture of its tempc result.
- Sits between the ADC front-end handshake and the combinational TemperatureCalculator instance.
- Owns the calculator's tc_base/tc_ref configuration and reports timeout and overrun errors.

Parameters:
- PERIOD, 1000: clk cycles between sample ticks; minimum 2.
- AVG_LOG2, 2: log2 of the number of samples averaged per measurement; range 0..4.
- TIMEOUT, 64: maximum clk cycles to wait for adc_done after adc_start.
- CALC_LAT, 1: clk cycles the calculator result is allowed to settle before capture; minimum 1.
- BASE_RST, 32'h0000_0000: reset value of calc_base.
- REF_RST, 8'h18: reset value of calc_ref.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  enables the periodic tick counter.
- start  in  1  one-cycle manual trigger; honoured only in IDLE.
- cfg_we  in  1  configuration write strobe.
- cfg_base  in  32  new tc_base value.
- cfg_ref  in  8  new tc_ref value.
- err_clr  in  1  clears both sticky error flags.
- adc_start  out  1  one-cycle conversion request.
- adc_done  in  1  one-cycle conversion-complete strobe.
- adc_data_in  in  16  ADC sample, valid when adc_done=1.
- calc_base  out  32  drives calculator tc_base.
- calc_ref  out  8  drives calculator tc_ref.
- calc_adc  out  16  drives calculator adc_data (the averaged sample).
- calc_tempc  in  32  calculator tempc result.
- temp_out  out  32  last captured temperature.
- temp_valid  out  1  one-cycle pulse when temp_out updates.
- busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  sticky flag: a conversion timed out.
- err_overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (async, any state): state=IDLE; every output 0, except calc_base=BASE_RST and calc_ref=REF_RST. Counters, accumulator and pending flag are cleared. Any in-flight measurement is discarded.
- Tick counter:
  - enable=1: counts 0..PERIOD-1, wraps to 0, and asserts tick on the cycle it holds PERIOD-1.
  - enable=0: counter held at 0.
  - Deasserting enable mid-measurement does not abort the measurement.
- Trigger = tick OR start.
  - Trigger in IDLE: go to CONV.
  - Tick while busy: dropped and err_overrun set.
  - start while busy: ignored, no flag.
- States:
  - IDLE: wait for trigger. On trigger: acc=0, sample count=0, go to CONV.
  - CONV:
    - adc_start=1 on the first cycle in CONV only; timeout counter starts.
    - adc_done=1: acc += adc_data_in, count++.
    - If count reaches 2^AVG_LOG2: calc_adc <= acc_new >> AVG_LOG2 (truncate), go to CALC.
    - Otherwise re-enter CONV, giving a new adc_start on the next cycle.
    - TIMEOUT cycles elapse without adc_done: set err_timeout, go to IDLE. No temp_valid, calc_adc unchanged, partial acc discarded.
    - adc_done on the same cycle the timeout expires counts as done.
  - CALC: wait CALC_LAT cycles, then temp_out <= calc_tempc, temp_valid=1 for one cycle, go to IDLE.
- Latency: temp_valid rises CALC_LAT+1 cycles after the edge that latches the final sample.
- Accumulator width is 16+AVG_LOG2 bits, so no overflow. Example: 4 samples of 16'hFFFF average to 16'hFFFF.
- adc_done outside CONV is ignored.
- Configuration writes:
  - cfg_we in IDLE: calc_base/calc_ref update on that edge, including when a trigger occurs on the same cycle.
  - cfg_we while busy: values go to shadow registers and pending=1. Multiple writes while busy: last write wins.
  - Pending values are applied on the first cycle in IDLE, so calc_base/calc_ref never change during CONV or CALC.
- err_clr clears both flags. A flag set on the same cycle as err_clr wins (stays set).

Test Plan:
- Averaging (PERIOD=20, AVG_LOG2=2, CALC_LAT=1): enable=1; ADC returns 16'h3080, 16'h3082, 16'h3081, 16'h3083, each 3 cycles after adc_start.
  - Required: exactly 4 adc_start pulses; calc_adc=16'h3081.
  - Required: temp_valid one cycle, with temp_out = calc_tempc sampled 2 cycles after the 4th adc_done.
- Timeout (TIMEOUT=8): start pulse, adc_done never asserted.
  - Required: err_timeout=1 after 8 cycles; busy falls; no temp_valid.
  - Then err_clr -> err_timeout=0.
- Overrun (PERIOD=4, ADC delay 10 cycles): enable=1.
  - Required: err_overrun=1 at the first tick during CONV; the measurement still completes with temp_valid=1.
- Config while busy: cfg_we with base=32'hAAAAAAAA, ref=8'hC6 during CONV.
  - Required: calc_base/calc_ref unchanged until busy=0, then equal to the new values on the next edge.
  - cfg_we in IDLE with ref=8'h18: immediate update.
- Reset mid-CALC: assert rst asynchronously.
  - Required: same-cycle busy=0, temp_valid=0, temp_out=0, calc_ref=REF_RST.
  - After release, a start pulse gives a normal measurement.
- Saturation boundary: 4 samples of 16'hFFFF -> calc_adc=16'hFFFF. With AVG_LOG2=0, a single sample passes through unchanged.

Source files
------------

// File: rtl/temp_sample_controller.sv
// rtl/temp_sample_controller.sv - measurement sequencer: ADC sampling, averaging, calculator capture
module temp_sample_controller #(
  parameter int          PERIOD   = 1000,
  parameter int          AVG_LOG2 = 2,
  parameter int          TIMEOUT  = 64,
  parameter int          CALC_LAT = 1,
  parameter logic [31:0] BASE_RST = 32'h0000_0000,
  parameter logic [7:0]  REF_RST  = 8'h18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic        cfg_we,
  input  logic [31:0] cfg_base,
  input  logic [7:0]  cfg_ref,
  input  logic        err_clr,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [15:0] adc_data_in,
  output logic [31:0] calc_base,
  output logic [7:0]  calc_ref,
  output logic [15:0] calc_adc,
  input  logic [31:0] calc_tempc,
  output logic [31:0] temp_out,
  output logic        temp_valid,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int PCW   = $clog2(PERIOD);
  localparam int TOW   = $clog2(TIMEOUT + 1);
  localparam int CLW   = $clog2(CALC_LAT + 1);
  localparam int CNTW  = AVG_LOG2 + 1;
  localparam logic [CNTW-1:0] NSAMP = CNTW'(1 << AVG_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_CALC} state_t;

  state_t             state_q, state_d;
  logic [PCW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [TOW-1:0]     to_cnt_q, to_cnt_d;
  logic [CLW-1:0]     calc_cnt_q, calc_cnt_d;
  logic [CNTW-1:0]    smp_cnt_q, smp_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_new;
  logic               adc_start_q, adc_start_d;
  logic [15:0]        calc_adc_q, calc_adc_d;
  logic [31:0]        calc_base_q, calc_base_d, shadow_base_q, shadow_base_d;
  logic [7:0]         calc_ref_q, calc_ref_d, shadow_ref_q, shadow_ref_d;
  logic               pending_q, pending_d;
  logic [31:0]        temp_out_q, temp_out_d;
  logic               temp_valid_q, temp_valid_d;
  logic               err_to_q, err_to_d, err_ov_q, err_ov_d;
  logic               tick, to_set;

  assign tick       = enable && (tick_cnt_q == PCW'(PERIOD - 1));
  assign tick_cnt_d = (!enable || tick) ? '0 : tick_cnt_q + PCW'(1);
  assign acc_new    = acc_q + ACC_W'(adc_data_in);

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    calc_cnt_d    = calc_cnt_q;
    smp_cnt_d     = smp_cnt_q;
    acc_d         = acc_q;
    adc_start_d   = 1'b0;
    calc_adc_d    = calc_adc_q;
    temp_out_d    = temp_out_q;
    temp_valid_d  = 1'b0;
    to_set        = 1'b0;
    calc_base_d   = calc_base_q;
    calc_ref_d    = calc_ref_q;
    shadow_base_d = shadow_base_q;
    shadow_ref_d  = shadow_ref_q;
    pending_d     = pending_q;

    case (state_q)
      S_IDLE: begin
        if (tick || start) begin
          acc_d       = '0;
          smp_cnt_d   = '0;
          to_cnt_d    = '0;
          adc_start_d = 1'b1;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        // a done arriving on the expiry cycle still counts as a sample
        if (adc_done) begin
          acc_d     = acc_new;
          smp_cnt_d = smp_cnt_q + CNTW'(1);
          to_cnt_d  = '0;
          if (smp_cnt_q + CNTW'(1) == NSAMP) begin
            calc_adc_d = 16'(acc_new >> AVG_LOG2);
            calc_cnt_d = '0;
            state_d    = S_CALC;
          end else begin
            adc_start_d = 1'b1;
          end
        end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
          to_set  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      S_CALC: begin
        if (calc_cnt_q == CLW'(CALC_LAT)) begin
          temp_out_d   = calc_tempc;
          temp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          calc_cnt_d = calc_cnt_q + CLW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // calculator config is frozen while busy; writes then wait in the shadow
    if (state_q == S_IDLE) begin
      if (pending_q) begin
        calc_base_d = shadow_base_q;
        calc_ref_d  = shadow_ref_q;
        pending_d   = 1'b0;
      end
      if (cfg_we) begin
        calc_base_d = cfg_base;
        calc_ref_d  = cfg_ref;
      end
    end else if (cfg_we) begin
      shadow_base_d = cfg_base;
      shadow_ref_d  = cfg_ref;
      pending_d     = 1'b1;
    end

    err_to_d = (err_to_q & ~err_clr) | to_set;
    err_ov_d = (err_ov_q & ~err_clr) | (tick && state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      to_cnt_q      <= '0;
      calc_cnt_q    <= '0;
      smp_cnt_q     <= '0;
      acc_q         <= '0;
      adc_start_q   <= 1'b0;
      calc_adc_q    <= '0;
      calc_base_q   <= BASE_RST;
      calc_ref_q    <= REF_RST;
      shadow_base_q <= '0;
      shadow_ref_q  <= '0;
      pending_q     <= 1'b0;
      temp_out_q    <= '0;
      temp_valid_q  <= 1'b0;
      err_to_q      <= 1'b0;
      err_ov_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      to_cnt_q      <= to_cnt_d;
      calc_cnt_q    <= calc_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      acc_q         <= acc_d;
      adc_start_q   <= adc_start_d;
      calc_adc_q    <= calc_adc_d;
      calc_base_q   <= calc_base_d;
      calc_ref_q    <= calc_ref_d;
      shadow_base_q <= shadow_base_d;
      shadow_ref_q  <= shadow_ref_d;
      pending_q     <= pending_d;
      temp_out_q    <= temp_out_d;
      temp_valid_q  <= temp_valid_d;
      err_to_q      <= err_to_d;
      err_ov_q      <= err_ov_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign calc_base   = calc_base_q;
  assign calc_ref    = calc_ref_q;
  assign calc_adc    = calc_adc_q;
  assign temp_out    = temp_out_q;
  assign temp_valid  = temp_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule
